uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Receive side of the UART; consumes the serial line driven by the transmitter's out_tx.
- Oversamples rx against the same 16-bit baud divisor (brd) the transmitter uses. Frames 8N1 characters, LSB first.
- Buffers received bytes in an internal FIFO. The core drains bytes through a first-word-fall-through read port.
- Reports framing and overrun errors.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..64.
- SYNC_STAGES, 2, flip-flops in the rx input synchroniser; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idles high.
- brd  input  16  bit period in clk cycles; values below 4 hold the receiver in IDLE.
- rd_en  input  1  pops the FIFO head when not empty.
- data_out  output  8  FIFO head byte; valid while fifo_empty=0.
- fifo_empty  output  1  FIFO holds no bytes.
- fifo_full  output  1  FIFO holds DEPTH bytes.
- rx_busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a good byte arrives with the FIFO full and no pop.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; counters clear; synchroniser flops preset to 1; FIFO pointers and count clear.
  - Outputs: data_out=0, fifo_empty=1, fifo_full=0, rx_busy=0, frame_err=0, overrun=0.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Synchronisation: the FSM sees rx_s, which is rx delayed by SYNC_STAGES cycles.
- Counters: baud_cnt is 16 bits, counts 0..brd-1, then wraps to 0. bit_idx is 3 bits. half = brd>>1.
- FSM (rx_state_t):
  - IDLE: rx_s=0 and brd>=4 -> START, baud_cnt=0.
  - START: when baud_cnt==half: rx_s=0 -> DATA with baud_cnt=0 and bit_idx=0; rx_s=1 -> IDLE (glitch rejected).
  - DATA: when baud_cnt==brd-1, sample rx_s into shift[bit_idx] (LSB first).
    - bit_idx==7 -> STOP; otherwise bit_idx++.
  - STOP: when baud_cnt==brd-1, sample rx_s.
    - 1: push byte (or raise overrun), go to IDLE.
    - 0: frame_err pulse, byte discarded, go to IDLE.
  - Sampling points therefore fall at bit centres.
- brd is sampled continuously. Software must not change brd while rx_busy=1.
  - If brd drops below baud_cnt mid-frame, baud_cnt wraps at 16 bits; this is accepted, not guarded.
- FIFO:
  - Push happens on the clk edge of the STOP sample. fifo_empty falls, and data_out is valid, the following cycle.
  - Pop: rd_en=1 with fifo_empty=0 advances the head. rd_en while empty is ignored.
  - Simultaneous push and pop while full: the pop frees a slot; the push is accepted; no overrun.
  - Simultaneous push and pop while empty: the pop is ignored; the push is accepted.
  - Push while full with no pop: the byte is dropped and overrun pulses for one cycle; FIFO contents are unchanged.
  - data_out is the registered head word, combinational from the storage array and read pointer; it holds its last value while empty.
- Total latency: about SYNC_STAGES + half + 9*brd cycles from the rx falling edge to fifo_empty=0.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP, sampled at brd-1.
  - Adds input parity_odd (1 = odd parity, 0 = even) and output parity_err (one-cycle pulse).
  - On mismatch: parity_err pulses at the STOP sample, the byte is discarded, and the FSM continues to STOP normally. frame_err may pulse in the same cycle.
- When undefined: no PARITY state, no parity ports; the frame is 8N1 only.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP}; PARITY stays in the enum even when the feature is compiled out.
  - Constants DATA_BITS=8 and BRD_MIN=4.
- Sub-module uart_rx_fifo: parameter DEPTH; ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full, overflow.
- uart_receiver instantiates uart_rx_fifo; the synchroniser, counters and FSM live in the top.

Test Plan:
- brd=16; send 0xA5 8N1 at 16 clk/bit -> fifo_empty falls about 154 cycles after the rx falling edge; data_out=0xA5; frame_err=0.
- brd=16; 3-cycle low glitch on rx -> START rejects it at the half-bit sample; state returns to IDLE; FIFO stays empty; no error pulses.
- brd=16; send 0x3C with the stop bit held low -> frame_err pulses exactly 1 cycle; fifo_empty stays 1.
- DEPTH=8; send 9 bytes 0x00..0x08 without rd_en -> fifo_full=1 after the 8th byte; the 9th raises one overrun pulse; popping yields 0x00..0x07 in order.
- FIFO full; assert rd_en in the same cycle as the 9th byte's stop sample -> no overrun; final contents 0x01..0x08.
- Assert rst mid-DATA of 0xFF, then send 0x11 -> only 0x11 appears; all outputs hold reset values during rst.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Contents: rx_state_t FSM encoding, data width, baud divisor width and minimum.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BRD_W     = 16;
    localparam int unsigned BRD_MIN   = 4;

    // PARITY is always present so the encoding is identical in every build.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with a first-word-fall-through read port.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    push request and byte
//   rd_en             pop the head when not empty
//   rd_data           head byte, combinational from storage and read pointer
//   empty, full       registered occupancy flags
//   overflow          one-cycle pulse when a push is dropped (full, no pop)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic                 do_pop;
    logic                 do_push;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    always_comb begin
        do_pop    = rd_en && (count != '0);
        do_push   = wr_en && ((count != CW'(DEPTH)) || do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == CW'(DEPTH));
            overflow <= wr_en && !do_push;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: rx synchroniser, oversampling bit timer, 8N1 framing FSM and
// a receive FIFO. Optional parity checking is compiled in with UART_RX_PARITY_EN.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rx                 asynchronous serial input, idles high
//   brd                bit period in clk cycles; below 4 holds the receiver idle
//   rd_en              pop the FIFO head
//   data_out           FIFO head byte, valid while fifo_empty=0
//   fifo_empty/full    FIFO occupancy flags
//   rx_busy            a frame is in progress
//   frame_err          one-cycle pulse on a low stop bit
//   overrun            one-cycle pulse when a good byte is dropped on a full FIFO
//   parity_odd         (UART_RX_PARITY_EN) 1 = odd parity, 0 = even
//   parity_err         (UART_RX_PARITY_EN) one-cycle pulse on parity mismatch
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [BRD_W-1:0]     brd,
    input  logic                 rd_en,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] data_out,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_t              state;
    logic [BRD_W-1:0]       baud_cnt;
    logic [BRD_W-1:0]       half;
    logic                   baud_done;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   push_c;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad;
`endif

    // Synchroniser presets high so reset looks like an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign half      = brd >> 1;
    assign baud_done = (baud_cnt == brd - BRD_W'(1));
    assign rx_busy   = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    assign push_c = (state == STOP) && baud_done && rx_s && !par_bad;
`else
    assign push_c = (state == STOP) && baud_done && rx_s;
`endif

    // Framing FSM: start bit verified at half period, then one sample per bit centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s && (brd >= BRD_W'(BRD_MIN))) begin
                        state <= START;
                    end
                end
                START: begin
                    if (baud_cnt == half) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BRD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BRD_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        par_bad  <= (rx_s != ((^shift) ^ parity_odd));
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BRD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                        state     <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BRD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push_c),
        .wr_data  (shift),
        .rd_en    (rd_en),
        .rd_data  (data_out),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (overrun)
    );

endmodule
